// File: rtl/twiddle_fetch_pkg.sv
// Shared FFT constants and helpers for the twiddle fetch block.
//   FFT_R / FFT_N / FFT_W : default log2 size, size, and twiddle component width
//   TW_DEPTH               : quarter-wave cosine table depth (N/4 + 1)
//   TW_ONE                 : Q2.(W-2) representation of 1.0
//   TW_LATENCY             : exponent-in to twiddle-out latency in cycles
//   tw_cos_q()             : elaboration-time cos(2*pi*m/n) scaled to Q2.(w-2)
package twiddle_fetch_pkg;

    localparam int FFT_R      = 5;
    localparam int FFT_N      = 1 << FFT_R;
    localparam int FFT_W      = 16;
    localparam int TW_DEPTH   = FFT_N / 4 + 1;
    localparam int TW_ONE     = 1 << (FFT_W - 2);
    localparam int TW_LATENCY = 3;

    // Per-entry control carried alongside the table reads.
    typedef struct packed {
        logic inv;     // conjugate (inverse transform)
        logic region;  // k lies in N/4+1 .. N/2-1
    } tw_ctl_t;

    // pi in Q30
    localparam longint TW_PI_Q30 = 64'sd3373259426;

    // cos(2*pi*m/n) in Q2.(w-2), rounded to nearest with ties away from zero.
    // Integer-only Taylor series in Q30 so the table folds to constants at
    // elaboration. Intended for m in 0..n/4 (|x| <= pi/2) and w <= 31.
    function automatic longint tw_cos_q(input int m, input int n, input int w);
        longint x, x2, term, sum, half;
        int     sh;
        x    = (2 * TW_PI_Q30 * m) / n;
        x2   = (x * x) >>> 30;
        term = longint'(1) <<< 30;
        sum  = term;
        for (int i = 1; i <= 10; i++) begin
            term = -((term * x2) >>> 30) / ((2 * i - 1) * (2 * i));
            sum  = sum + term;
        end
        sh   = 30 - (w - 2);
        half = longint'(1) <<< (sh - 1);
        // Round on the magnitude so the result is symmetric about zero.
        if (sum >= 0)
            return (sum + half) >>> sh;
        else
            return -((-sum + half) >>> sh);
    endfunction

endpackage

// File: rtl/twiddle_fetch_tw_quarter_rom.sv
// Quarter-wave cosine table C[m] = cos(2*pi*m/N), m = 0..N/4, Q2.(W-2).
// Two independent read ports with registered outputs.
//   clk, rst_n     : clock, asynchronous active-low reset (clears read regs)
//   addr_a, addr_b : read addresses
//   data_a, data_b : registered table contents, one cycle after address
module tw_quarter_rom
    import twiddle_fetch_pkg::*;
#(
    parameter int N  = FFT_N,
    parameter int W  = FFT_W,
    parameter int AW = $clog2(N / 4 + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [AW-1:0]       addr_a,
    input  logic [AW-1:0]       addr_b,
    output logic signed [W-1:0] data_a,
    output logic signed [W-1:0] data_b
);

    localparam int DEPTH = N / 4 + 1;

    logic signed [W-1:0] rom [2**AW];

    // Address space is padded to a power of two; unused slots read as zero.
    for (genvar m = 0; m < 2**AW; m++) begin : g_rom
        localparam logic signed [W-1:0] VAL =
            (m < DEPTH) ? W'(tw_cos_q((m < DEPTH) ? m : 0, N, W)) : '0;
        assign rom[m] = VAL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_a <= '0;
            data_b <= '0;
        end else begin
            data_a <= rom[addr_a];
            data_b <= rom[addr_b];
        end
    end

endmodule

// File: rtl/twiddle_fetch.sv
// Twiddle factor fetch: maps exponent k (0..N/2-1) to W_N^k = cos - j*sin
// (or its conjugate) using a quarter-wave cosine table. 3-stage pipeline,
// one exponent per cycle, no backpressure.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_exp_valid           : i_exponent / i_inv valid this cycle
//   i_exponent [R-2:0]    : twiddle exponent k
//   i_inv                 : 1 = inverse transform (conjugate twiddle)
//   o_tw_valid            : o_tw_re / o_tw_im valid (3 cycles after input)
//   o_tw_re, o_tw_im      : signed Q2.(W-2) twiddle, held while not valid
module twiddle_fetch
    import twiddle_fetch_pkg::*;
#(
    parameter int R = FFT_R,
    parameter int N = 1 << R,
    parameter int W = FFT_W
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_exp_valid,
    input  logic [R-2:0]        i_exponent,
    input  logic                i_inv,
    output logic                o_tw_valid,
    output logic signed [W-1:0] o_tw_re,
    output logic signed [W-1:0] o_tw_im
);

    localparam int QTR = N / 4;
    localparam int AW  = $clog2(QTR + 1);

    logic [TW_LATENCY-1:0] vld_pipe;
    logic [R-2:0]          k_s1;
    tw_ctl_t               ctl_s1, ctl_s2;
    logic [AW-1:0]         addr_re, addr_im;
    logic signed [W-1:0]   rom_re, rom_im;

    // Valid shift register; bit i marks stage S(i+1) holding a live entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            vld_pipe <= '0;
        else
            vld_pipe <= {vld_pipe[TW_LATENCY-2:0], i_exp_valid};
    end

    assign o_tw_valid = vld_pipe[TW_LATENCY-1];

    // S1: capture exponent, conjugate select and region flag.
    always_ff @(posedge i_clk) begin
        if (i_exp_valid) begin
            k_s1          <= i_exponent;
            ctl_s1.inv    <= i_inv;
            ctl_s1.region <= (int'(i_exponent) > QTR);
        end
    end

    // Table addresses. First quadrant: re = C[k], im = -C[N/4-k].
    // Second quadrant (k' = k-N/4): re = -C[N/4-k'] = -C[N/2-k], im = -C[k'].
    always_comb begin
        if (ctl_s1.region) begin
            addr_re = AW'(N / 2 - int'(k_s1));
            addr_im = AW'(int'(k_s1) - QTR);
        end else begin
            addr_re = AW'(int'(k_s1));
            addr_im = AW'(QTR - int'(k_s1));
        end
    end

    // S2: registered table reads.
    tw_quarter_rom #(
        .N  (N),
        .W  (W),
        .AW (AW)
    ) u_rom (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .addr_a (addr_re),
        .addr_b (addr_im),
        .data_a (rom_re),
        .data_b (rom_im)
    );

    always_ff @(posedge i_clk) begin
        if (vld_pipe[0])
            ctl_s2 <= ctl_s1;
    end

    // S3: apply signs. Table magnitude never exceeds 2**(W-2), so negation
    // cannot overflow, and negating zero yields plain zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_tw_re <= '0;
            o_tw_im <= '0;
        end else if (vld_pipe[1]) begin
            o_tw_re <= ctl_s2.region ? -rom_re : rom_re;
            o_tw_im <= ctl_s2.inv    ? rom_im  : -rom_im;
        end
    end

endmodule

// File: tb/tb_twiddle_fetch.sv
module tb_twiddle_fetch;

    localparam int R = 5;
    localparam int N = 32;
    localparam int W = 16;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b1;
    logic                vld   = 1'b0;
    logic                inv   = 1'b0;
    logic [R-2:0]        ex    = '0;
    logic                ovld;
    logic signed [W-1:0] ore, oim;

    twiddle_fetch #(.R(R), .N(N), .W(W)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_exp_valid (vld),
        .i_exponent  (ex),
        .i_inv       (inv),
        .o_tw_valid  (ovld),
        .o_tw_re     (ore),
        .o_tw_im     (oim)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    longint cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int     k;
        int     re;
        int     im;
        int     tol;
        longint due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   last_re  = 0;
    int   last_im  = 0;
    int   last_tol = 0;

    task automatic chk(string tag, longint got, longint want, int tol);
        longint d;
        d = got - want;
        if (d < 0) d = -d;
        checks++;
        assert (d <= tol) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, got, want, tol);
        end
    endtask

    function automatic int rnd(real r);
        if (r >= 0.0) return $rtoi(r + 0.5);
        else          return -$rtoi(-r + 0.5);
    endfunction

    // Drive one valid exponent in the current cycle and log its expectation.
    task automatic send_now(int k, bit iv, int re, int im, int tol);
        exp_t e;
        vld   = 1'b1;
        ex    = k[R-2:0];
        inv   = iv;
        e.k   = k;
        e.re  = re;
        e.im  = im;
        e.tol = tol;
        e.due = cyc + 3;
        sb.push_back(e);
    endtask

    task automatic send(int k, bit iv, int re, int im, int tol);
        @(negedge clk);
        send_now(k, iv, re, im, tol);
    endtask

    task automatic send_ref(int k, bit iv);
        real a;
        int  re, im;
        a  = 2.0 * 3.14159265358979323846 * k / N;
        re = rnd($cos(a) * 16384.0);
        im = -rnd($sin(a) * 16384.0);
        if (iv) im = -im;
        send(k, iv, re, im, 1);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(negedge clk);
            vld = 1'b0;
        end
    endtask

    // Output monitor: every valid must match the scoreboard head on its due
    // cycle; between valids the outputs must hold the last result.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due < cyc) begin
            chk("missing_output", cyc, sb[0].due, 0);
            void'(sb.pop_front());
        end
        if (ovld) begin
            if (sb.size() == 0)
                chk("unexpected_valid", 1, 0, 0);
            else if (sb[0].due != cyc)
                chk("valid_timing", cyc, sb[0].due, 0);
            else begin
                mon_e = sb.pop_front();
                chk($sformatf("re_k%0d", mon_e.k), ore, mon_e.re, mon_e.tol);
                chk($sformatf("im_k%0d", mon_e.k), oim, mon_e.im, mon_e.tol);
                last_re  = mon_e.re;
                last_im  = mon_e.im;
                last_tol = mon_e.tol;
            end
        end else begin
            chk("hold_re", ore, last_re, last_tol);
            chk("hold_im", oim, last_im, last_tol);
        end
    end

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", ovld, 0, 0);
        chk("rst_re", ore, 0, 0);
        chk("rst_im", oim, 0, 0);
        idle(2);

        // Release and present an exponent on the first edge out of reset
        rst_n = 1'b1;
        send_now(0, 1'b0, 16384, 0, 0);
        idle(2);

        // Directed quadrant points
        send(8, 1'b0, 0, -16384, 0);
        send(4, 1'b0, 11585, -11585, 0);
        send(12, 1'b0, -11585, -11585, 0);
        idle(3);
        send(4, 1'b1, 11585, 11585, 0);
        send(15, 1'b1, -16069, 3196, 0);
        idle(5);

        // Back-to-back stream k = 0..15
        for (int k = 0; k < N / 2; k++)
            send_ref(k, 1'b0);
        idle(5);

        // Exponent-generator order over all stages, one valid in three cycles
        for (int s = 0; s < R; s++) begin
            for (int j = 0; j < N / 2; j++) begin
                send_ref((j % (N >> (s + 1))) << s, (j % 5) == 0);
                idle(2);
            end
        end
        idle(5);

        // Reset with two exponents in flight
        send_ref(3, 1'b0);
        send_ref(9, 1'b1);
        idle(1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", ovld, 0, 0);
        chk("midrst_re", ore, 0, 0);
        chk("midrst_im", oim, 0, 0);
        sb.delete();
        last_re  = 0;
        last_im  = 0;
        last_tol = 0;
        idle(3);
        rst_n = 1'b1;
        send_now(8, 1'b0, 0, -16384, 0);
        idle(8);

        chk("scoreboard_empty", sb.size(), 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/twiddle_fetch.md
TWIDDLE_FETCH -- requirements
Module: twiddle_fetch

Interface
REQ-001 SHALL have parameter R, default 5, meaning log2 of the FFT size.
REQ-002 SHALL have parameter N, default 32, meaning FFT size, equal to 2**R.
REQ-003 SHALL have parameter W, default 16, meaning twiddle component width in bits, signed Q2.(W-2).
REQ-004 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port i_exp_valid, input, 1 bit: i_exponent and i_inv are valid this cycle.
REQ-007 SHALL have port i_exponent, input, R-1 bits: twiddle exponent k, range 0..N/2-1, as produced by the exponent generator.
REQ-008 SHALL have port i_inv, input, 1 bit: 1 selects the inverse transform (conjugate twiddle), sampled with i_exp_valid.
REQ-009 SHALL have port o_tw_valid, output, 1 bit: o_tw_re and o_tw_im are valid this cycle.
REQ-010 SHALL have port o_tw_re, output, W bits signed: real part of W_N^k.
REQ-011 SHALL have port o_tw_im, output, W bits signed: imaginary part of W_N^k.

Function
REQ-012 SHALL output W_N^k = cos(2*pi*k/N) - j*sin(2*pi*k/N) for forward, and its conjugate when i_inv=1.
REQ-013 SHALL scale so that 1.0 = 2**(W-2) (16384 at W=16); values rounded to nearest, ties away from zero.
REQ-014 SHALL derive all values from a quarter-wave cosine table C[m] = cos(2*pi*m/N), m = 0..N/4 (N/4+1 entries).
REQ-015 SHALL, for k in 0..N/4: re = C[k], im = -C[N/4-k].
REQ-016 SHALL, for k in N/4+1..N/2-1, with k' = k-N/4: re = -C[N/4-k'], im = -C[k'].
REQ-017 SHALL, when i_inv=1, negate im after REQ-015/016; re unchanged.
REQ-018 SHALL be a 3-stage pipeline: S1 registers k, inv and region flag and computes both table addresses; S2 registers both table reads; S3 applies signs and registers outputs.
REQ-019 SHALL assert o_tw_valid exactly 3 cycles after the cycle i_exp_valid was sampled high, carrying the result for that exponent.
REQ-020 SHALL accept a new exponent every cycle, no backpressure, no bubbles inserted; sparse input (e.g. one valid in 3 cycles) yields equally sparse output.
REQ-021 SHALL hold o_tw_re/o_tw_im at their last valid values while o_tw_valid=0.
REQ-022 SHALL never overflow on negation: table magnitude is at most 2**(W-2).
REQ-023 SHALL produce exact zero (no negative-zero artefacts) for k=0 imag and k=N/4 real.

Reset
REQ-024 SHALL, on i_rst_n=0, asynchronously clear all pipeline valid bits, o_tw_valid, o_tw_re and o_tw_im to 0.
REQ-025 SHALL discard all in-flight exponents on reset mid-stream; the first o_tw_valid after release occurs 3 cycles after the first post-reset sampled i_exp_valid.
REQ-026 SHALL sample i_exp_valid normally on the first rising edge with i_rst_n=1.

Structure
REQ-027 SHALL place R, N, W, the table depth N/4+1, the Q-format one-constant 2**(W-2), and the pipeline latency constant (3) in the shared FFT package.
REQ-028 SHALL implement the table as one sub-module, tw_quarter_rom: two read ports with registered outputs forming stage S2, contents computed at elaboration from N and W.
REQ-029 SHALL contain no other sub-modules.

Verification (N=32, W=16)
REQ-030 SHALL check k=0, inv=0 -> 3 cycles later re=16384, im=0.
REQ-031 SHALL check k=8 -> re=0, im=-16384; k=4 -> re=11585, im=-11585; k=12 -> re=-11585, im=-11585.
REQ-032 SHALL check k=4, inv=1 -> re=11585, im=+11585; k=15, inv=1 -> re=-16069, im=+3196.
REQ-033 SHALL check back-to-back stream k=0..15, valid every cycle -> 16 consecutive valid outputs starting cycle 3, each matching a double-precision reference to within 1 LSB.
REQ-034 SHALL check a stream driven by the exponent generator (valid 1-in-3 over all R stages) -> every output matches the reference for its exponent, with spacing preserved.
REQ-035 SHALL check i_rst_n pulsed low with 2 exponents in flight -> o_tw_valid=0 and outputs 0 immediately, with no stale result appearing after release.
